// File: rtl/nic_flit_bridge.sv
// nic_flit_bridge: packs CPU NIC words into NoC flits (TX) and unpacks FIFO-buffered flits into words (RX).
// Optional build macro NIC_BRIDGE_STATS_EN enables saturating flit counters; otherwise they read 0.
module nic_flit_bridge #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_FLIT = 4,
    parameter int RX_DEPTH       = 4,
    parameter int CNT_W          = 16,
    localparam int FLIT_W        = WORD_W * WORDS_PER_FLIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] cpu_tx,
    input  logic              cpu_tx_vld,
    output logic              cpu_tx_rdy,
    output logic [FLIT_W-1:0] flit_tx,
    output logic              flit_tx_vld,
    input  logic              flit_tx_rdy,
    input  logic [FLIT_W-1:0] flit_rx,
    input  logic              flit_rx_vld,
    output logic              flit_rx_rdy,
    output logic [WORD_W-1:0] cpu_rx,
    output logic              cpu_rx_vld,
    input  logic              cpu_rx_rdy,
    output logic [CNT_W-1:0]  tx_flit_cnt,
    output logic [CNT_W-1:0]  rx_flit_cnt
);

    // Handshake rule on every port pair: a beat moves on a rising edge where vld && rdy;
    // a raised vld keeps its data stable until that beat, and vld never waits on rdy.

    localparam int IDX_W = $clog2(WORDS_PER_FLIT);
    localparam int AW    = $clog2(RX_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FLIT - 1);

    typedef enum logic {
        FILL = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    tx_state_t         tx_state;
    tx_state_t         tx_state_nxt;
    logic [IDX_W-1:0]  tx_idx;
    logic [FLIT_W-1:0] tx_buf;
    logic              tx_word_hs;

    always_comb begin
        tx_state_nxt = tx_state;
        cpu_tx_rdy   = 1'b0;
        flit_tx_vld  = 1'b0;
        case (tx_state)
            FILL: begin
                cpu_tx_rdy = 1'b1;
                if (cpu_tx_vld && (tx_idx == LAST_IDX)) begin
                    tx_state_nxt = SEND;
                end
            end
            SEND: begin
                flit_tx_vld = 1'b1;
                if (flit_tx_rdy) begin
                    tx_state_nxt = FILL;
                end
            end
            default: tx_state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= FILL;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    assign tx_word_hs = cpu_tx_vld && cpu_tx_rdy;
    assign flit_tx    = tx_buf;

    // Lanes are overwritten in order, so no clear is needed between flits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_idx <= '0;
            tx_buf <= '0;
        end else if (tx_word_hs) begin
            tx_buf[int'(tx_idx)*WORD_W +: WORD_W] <= cpu_tx;
            tx_idx <= (tx_idx == LAST_IDX) ? '0 : tx_idx + 1'b1;
        end
    end

    logic [FLIT_W-1:0] rx_mem [RX_DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [IDX_W-1:0]  ridx;
    logic [FLIT_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_push;
    logic              rx_word_hs;
    logic              rx_pop;

    // Extra pointer MSB tells a full FIFO from an empty one when the index bits match.
    assign rx_empty   = (wptr == rptr);
    assign rx_full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign flit_rx_rdy = !rx_full;
    assign cpu_rx_vld  = !rx_empty;
    assign rx_push    = flit_rx_vld && !rx_full;
    assign rx_word_hs = cpu_rx_vld && cpu_rx_rdy;
    assign rx_pop     = rx_word_hs && (ridx == LAST_IDX);
    assign rx_head    = rx_mem[rptr[AW-1:0]];
    assign cpu_rx     = rx_empty ? '0 : rx_head[int'(ridx)*WORD_W +: WORD_W];

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wptr[AW-1:0]] <= flit_rx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            ridx <= '0;
        end else begin
            if (rx_push) begin
                wptr <= wptr + 1'b1;
            end
            if (rx_word_hs) begin
                ridx <= (ridx == LAST_IDX) ? '0 : ridx + 1'b1;
            end
            if (rx_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

`ifdef NIC_BRIDGE_STATS_EN
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;
    logic             tx_flit_hs;

    assign tx_flit_hs = flit_tx_vld && flit_tx_rdy;

    // Counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_flit_hs && (tx_cnt != '1)) begin
                tx_cnt <= tx_cnt + 1'b1;
            end
            if (rx_push && (rx_cnt != '1)) begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    assign tx_flit_cnt = tx_cnt;
    assign rx_flit_cnt = rx_cnt;
`else
    assign tx_flit_cnt = '0;
    assign rx_flit_cnt = '0;
`endif

endmodule
